// File: rtl/enc_pkg.sv
// Shared types and constants for the 4-to-2 synchronizing encoder.
// The state enum and code constants live here so that the encoder and any
// consumer (such as the 2-to-4 decoder) agree on the code mapping.
package enc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EMIT    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Code per request line; a decoder driving line (1 << code) recovers it.
  localparam logic [1:0] CODE_P = 2'b00;
  localparam logic [1:0] CODE_Q = 2'b01;
  localparam logic [1:0] CODE_R = 2'b10;
  localparam logic [1:0] CODE_S = 2'b11;

  // True when exactly one bit of the {s,r,q,p} vector is set.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Highest set line wins (s > r > q > p); exact for one-hot input.
  function automatic logic [1:0] encode_prio(input logic [3:0] v);
    if (v[3])      return CODE_S;
    else if (v[2]) return CODE_R;
    else if (v[1]) return CODE_Q;
    else           return CODE_P;
  endfunction

endpackage

// File: rtl/sync2.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset.
// Brings one asynchronous request line into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage shift; the first flop may go metastable, the second resolves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/encoder_4to2_sync.sv
// Debounced, handshaked 4-to-2 encoder for asynchronous one-hot requests.
// Each line is synchronized, the pattern must hold STABLE_CYCLES sampled
// cycles, then its code is presented with a valid/ready handshake. A line
// must fall back to idle before it can be emitted again.
// Optional build macro: ENC_PRIORITY_EN -- multi-hot accepts emit the code of
// the highest set line (with err); without it they only pulse err.
module encoder_4to2_sync #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p,
  input  logic q,
  input  logic r,
  input  logic s,
  output logic w,
  output logic z,
  output logic out_valid,
  input  logic out_ready,
  output logic err
);

  import enc_pkg::*;

  // Counter value on which a still-matching candidate is accepted.
  localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

  logic       p_sync, q_sync, r_sync, s_sync;
  logic [3:0] pat;

  state_e     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] code_q, code_d;
  logic       out_valid_q, out_valid_d;
  logic       err_q, err_d;

  sync2 u_sync_p (.clk(clk), .rst_n(rst_n), .d_i(p), .q_o(p_sync));
  sync2 u_sync_q (.clk(clk), .rst_n(rst_n), .d_i(q), .q_o(q_sync));
  sync2 u_sync_r (.clk(clk), .rst_n(rst_n), .d_i(r), .q_o(r_sync));
  sync2 u_sync_s (.clk(clk), .rst_n(rst_n), .d_i(s), .q_o(s_sync));

  assign pat = {s_sync, r_sync, q_sync, p_sync};

  // State register and datapath registers; reset discards any pending code.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= 4'd0;
      code_q      <= 2'b00;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Next-state and next-output logic for the debounce/emit/release cycle.
  // NOTE: every signal gets a hold/default value first so no path through
  // the case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pat != 4'd0) begin
          cand_d  = pat;
          cnt_d   = 4'd0;
          state_d = COUNT;
        end
      end

      COUNT: begin
        if (pat == 4'd0) begin
          state_d = IDLE;
        end else if (pat != cand_q) begin
          // Pattern moved: restart debounce on the new pattern.
          cand_d = pat;
          cnt_d  = 4'd0;
        end else if (cnt_q == CNT_LAST) begin
          if (is_onehot(cand_q)) begin
            code_d      = encode_prio(cand_q);
            out_valid_d = 1'b1;
            state_d     = EMIT;
          end else begin
            err_d = 1'b1;
`ifdef ENC_PRIORITY_EN
            code_d      = encode_prio(cand_q);
            out_valid_d = 1'b1;
            state_d     = EMIT;
`else
            state_d = RELEASE;
`endif
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      EMIT: begin
        // Inputs are ignored here; the code holds until it is consumed.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = RELEASE;
        end
      end

      RELEASE: begin
        if (pat == 4'd0) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign {w, z}    = code_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule
